// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin sharing of one dff among NUM_REQ requesters with q readback check.
module dff_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1,
  parameter int ERR_W   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         ff_data,
  input  logic [DATA_W-1:0]         ff_q,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic                      done_ok,
  output logic [ERR_W-1:0]          err_cnt
);
  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, sel_id, pick, rr_next;
  logic [ID_W:0] idx;
  logic found;
  logic [DATA_W-1:0] pick_data;
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (!found && req[idx[ID_W-1:0]]) begin
        pick = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign pick_data = DATA_W'(req_data >> (int'(pick) * DATA_W));
  assign rr_next = (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + 1'b1;
  // ff_data still holds the latched request data during CHECK, so it doubles as the reference
  assign done_ok = done && (ff_q == ff_data);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      sel_id  <= '0;
      gnt     <= '0;
      ff_data <= '0;
      done    <= 1'b0;
      done_id <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          sel_id  <= pick;
          ff_data <= pick_data;
          gnt     <= NUM_REQ'(1) << pick;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          done    <= 1'b1;
          done_id <= sel_id;
          state   <= CHECK;
        end
        CHECK: begin
          done   <= 1'b0;
          gnt    <= '0;
          rr_ptr <= rr_next;
          if (!done_ok && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dff_share_arb.sv
// tb_dff_share_arb: directed checks of arbitration order, dff readback and error counting.
module tb_dff_share_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] req_data = 4'b0000;
  logic [3:0] gnt;
  logic [0:0] ff_data, ff_q, q;
  logic       done, done_ok, inj = 1'b0;
  logic [1:0] done_id;
  logic [7:0] err_cnt;
  int checks = 0;
  int errors = 0;

  dff_share_arb dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .ff_data(ff_data), .ff_q(ff_q), .done(done), .done_id(done_id),
    .done_ok(done_ok), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // shared dff model; inj inverts its q to emulate a faulty flop
  always_ff @(posedge clk or negedge rst_n) q <= !rst_n ? 1'b0 : ff_data;
  assign ff_q = inj ? ~q : q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int id, input bit ok, input logic dat);
    @(negedge clk);
    chk("gnt_capture", 32'(gnt), 32'(1 << id));
    chk("done_capture", 32'(done), 0);
    chk("ff_data", 32'(ff_data), 32'(dat));
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("done_id", 32'(done_id), 32'(id));
    chk("done_ok", 32'(done_ok), 32'(ok));
    chk("gnt_check", 32'(gnt), 32'(1 << id));
    chk("ff_q", 32'(ff_q), 32'(ok ? dat : !dat));
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("gnt_idle", 32'(gnt), 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ff_data", 32'(ff_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_ok", 32'(done_ok), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    serve(0, 1'b1, 1'b0);
    req = 4'b0100; req_data = 4'b0100;
    serve(2, 1'b1, 1'b1);
    req = 4'b1001; req_data = 4'b1001;
    serve(3, 1'b1, 1'b1);
    serve(0, 1'b1, 1'b1);
    req = 4'b0010; req_data = 4'b0010;
    serve(1, 1'b1, 1'b1);
    req = 4'b1100; req_data = 4'b0000;
    @(negedge clk);
    chk("midrst_gnt_before", 32'(gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_ff_data", 32'(ff_data), 0);
    @(negedge clk);
    chk("midrst_no_done", 32'(done), 0);
    req = 4'b1111; req_data = 4'b0101;
    rst_n = 1'b1;
    serve(0, 1'b1, 1'b1);
    serve(1, 1'b1, 1'b0);
    serve(2, 1'b1, 1'b1);
    serve(3, 1'b1, 1'b0);
    serve(0, 1'b1, 1'b1);
    chk("err_cnt_clean", 32'(err_cnt), 0);
    req = 4'b0001; req_data = 4'b0001; inj = 1'b1;
    serve(0, 1'b0, 1'b1);
    chk("err_cnt_one", 32'(err_cnt), 1);
    for (int i = 2; i <= 300; i++) begin
      serve(0, 1'b0, 1'b1);
      if (i == 254) chk("err_cnt_254", 32'(err_cnt), 254);
      if (i == 255) chk("err_cnt_255", 32'(err_cnt), 255);
    end
    chk("err_cnt_sat", 32'(err_cnt), 255);
    req = 4'b0000; inj = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
